// File: rtl/cache_dm_param.sv
// Parametrised direct-mapped cache between a word-wide processor port
// and a line-wide memory port, with write-back or write-through policy.
module cache_dm_param #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int LINES          = 16,
    parameter bit WRITE_BACK     = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             PRead_request,
    input  logic                             PWrite_request,
    input  logic [ADDR_W-1:0]                PAddress,
    input  logic [DATA_W-1:0]                PWrite_data,
    output logic                             PRead_ready,
    output logic [DATA_W-1:0]                PRead_data,
    output logic                             PWrite_ready,
    output logic                             MRead_request,
    input  logic                             MRead_ready,
    input  logic [DATA_W*WORDS_PER_LINE-1:0] MRead_data,
    output logic                             MWrite_request,
    input  logic                             MWrite_ready,
    output logic [DATA_W*WORDS_PER_LINE-1:0] MWrite_data,
    output logic [WORDS_PER_LINE-1:0]        MWrite_mask,
    output logic [ADDR_W-1:0]                MAddress,
    output logic [CNT_W-1:0]                 hit_count,
    output logic [CNT_W-1:0]                 miss_count,
    output logic                             busy
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = DATA_W * WORDS_PER_LINE;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, EVICT, REFILL, MEMWR, RESP, RELEASE
    } state_t;

    state_t state, state_nx;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              is_wr_q;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] cur_line;
    logic              hit;

    assign off      = addr_q[OFF_W-1:0];
    assign idx      = addr_q[OFF_W +: IDX_W];
    assign tag      = addr_q[ADDR_W-1 -: TAG_W];
    assign cur_line = data_q[idx];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);

    function automatic logic [LINE_W-1:0] merge_word(
        input logic [LINE_W-1:0] line,
        input logic [OFF_W-1:0]  o,
        input logic [DATA_W-1:0] w
    );
        merge_word = line;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (o == OFF_W'(i)) begin
                merge_word[i*DATA_W +: DATA_W] = w;
            end
        end
    endfunction

    logic [DATA_W-1:0]         rd_word;
    logic [WORDS_PER_LINE-1:0] off_onehot;

    always_comb begin
        rd_word    = '0;
        off_onehot = '0;
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (off == OFF_W'(i)) begin
                rd_word       = cur_line[i*DATA_W +: DATA_W];
                off_onehot[i] = 1'b1;
            end
        end
    end

    logic              latch;
    logic              latch_wr;
    logic              hit_inc;
    logic              miss_inc;
    logic              line_we;
    logic [LINE_W-1:0] line_wdata;
    logic              set_valid;
    logic              set_dirty;
    logic              clr_dirty;

    always_comb begin
        state_nx   = state;
        latch      = 1'b0;
        latch_wr   = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        line_we    = 1'b0;
        line_wdata = cur_line;
        set_valid  = 1'b0;
        set_dirty  = 1'b0;
        clr_dirty  = 1'b0;
        unique case (state)
            IDLE: begin
                // A simultaneous read stays pending until the write retires.
                if (PWrite_request) begin
                    latch    = 1'b1;
                    latch_wr = 1'b1;
                    state_nx = LOOKUP;
                end else if (PRead_request) begin
                    latch    = 1'b1;
                    state_nx = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_inc  = hit;
                miss_inc = !hit;
                if (hit && is_wr_q) begin
                    line_we    = 1'b1;
                    line_wdata = merge_word(cur_line, off, wdata_q);
                    set_dirty  = WRITE_BACK;
                    state_nx   = WRITE_BACK ? RESP : MEMWR;
                end else if (hit) begin
                    state_nx = RESP;
                end else if (is_wr_q && !WRITE_BACK) begin
                    state_nx = MEMWR;
                end else if (valid_q[idx] && dirty_q[idx]) begin
                    state_nx = EVICT;
                end else begin
                    state_nx = REFILL;
                end
            end
            EVICT: begin
                if (MWrite_ready) begin
                    clr_dirty = 1'b1;
                    state_nx  = REFILL;
                end
            end
            REFILL: begin
                if (MRead_ready) begin
                    line_we    = 1'b1;
                    set_valid  = 1'b1;
                    set_dirty  = is_wr_q;
                    line_wdata = is_wr_q
                               ? merge_word(MRead_data, off, wdata_q)
                               : MRead_data;
                    state_nx   = RESP;
                end
            end
            MEMWR: begin
                if (MWrite_ready) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = RELEASE;
            end
            RELEASE: begin
                if (is_wr_q ? !PWrite_request : !PRead_request) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        PRead_ready    = 1'b0;
        PRead_data     = '0;
        PWrite_ready   = 1'b0;
        MRead_request  = 1'b0;
        MWrite_request = 1'b0;
        MWrite_data    = '0;
        MWrite_mask    = '0;
        MAddress       = '0;
        busy           = (state != IDLE);
        unique case (state)
            EVICT: begin
                MWrite_request = 1'b1;
                MAddress       = {tag_q[idx], idx, {OFF_W{1'b0}}};
                MWrite_data    = cur_line;
                MWrite_mask    = '1;
            end
            REFILL: begin
                MRead_request = 1'b1;
                MAddress      = {tag, idx, {OFF_W{1'b0}}};
            end
            MEMWR: begin
                MWrite_request = 1'b1;
                MAddress       = {tag, idx, {OFF_W{1'b0}}};
                MWrite_data    = {WORDS_PER_LINE{wdata_q}};
                MWrite_mask    = off_onehot;
            end
            RESP: begin
                if (is_wr_q) begin
                    PWrite_ready = 1'b1;
                end else begin
                    PRead_ready = 1'b1;
                    PRead_data  = rd_word;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            is_wr_q    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_nx;
            if (latch) begin
                addr_q  <= PAddress;
                wdata_q <= PWrite_data;
                is_wr_q <= latch_wr;
            end
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (set_valid) begin
                valid_q[idx] <= 1'b1;
            end
            if (clr_dirty) begin
                dirty_q[idx] <= 1'b0;
            end else if (line_we) begin
                dirty_q[idx] <= set_dirty;
            end
        end
    end

    // Line storage needs no reset: valid gates every use of it.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_q[idx] <= line_wdata;
            tag_q[idx]  <= tag;
        end
    end

endmodule

// File: tb/tb_cache_dm_param.sv
// Bench for cache_dm_param: a write-back instance with 2-bit counters and
// a write-through instance, checked through an event scoreboard.
module tb_cache_dm_param;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int WPL = 4;
    localparam int LW  = DW * WPL;

    typedef enum int {EV_RD, EV_WR, EV_MR, EV_MW} ev_e;

    typedef struct {
        int             dut;
        ev_e            kind;
        logic [AW-1:0]  addr;
        logic [LW-1:0]  data;
        logic [WPL-1:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           pr_req  [2];
    logic           pw_req  [2];
    logic [AW-1:0]  paddr   [2];
    logic [DW-1:0]  pwdata  [2];
    logic           pr_rdy  [2];
    logic [DW-1:0]  prdata  [2];
    logic           pw_rdy  [2];
    logic           mr_req  [2];
    logic           mr_rdy  [2];
    logic [LW-1:0]  mr_data [2];
    logic           mw_req  [2];
    logic           mw_rdy  [2];
    logic [LW-1:0]  mw_data [2];
    logic [WPL-1:0] mw_mask [2];
    logic [AW-1:0]  maddr   [2];
    logic           busy    [2];
    logic [1:0]     hit_a, miss_a;
    logic [15:0]    hit_b, miss_b;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    cache_dm_param #(
        .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL), .LINES(16),
        .WRITE_BACK(1'b1), .CNT_W(2)
    ) dut_wb (
        .clk(clk), .rst(rst),
        .PRead_request(pr_req[0]), .PWrite_request(pw_req[0]),
        .PAddress(paddr[0]), .PWrite_data(pwdata[0]),
        .PRead_ready(pr_rdy[0]), .PRead_data(prdata[0]),
        .PWrite_ready(pw_rdy[0]),
        .MRead_request(mr_req[0]), .MRead_ready(mr_rdy[0]),
        .MRead_data(mr_data[0]),
        .MWrite_request(mw_req[0]), .MWrite_ready(mw_rdy[0]),
        .MWrite_data(mw_data[0]), .MWrite_mask(mw_mask[0]),
        .MAddress(maddr[0]),
        .hit_count(hit_a), .miss_count(miss_a), .busy(busy[0])
    );

    cache_dm_param #(
        .ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL), .LINES(16),
        .WRITE_BACK(1'b0), .CNT_W(16)
    ) dut_wt (
        .clk(clk), .rst(rst),
        .PRead_request(pr_req[1]), .PWrite_request(pw_req[1]),
        .PAddress(paddr[1]), .PWrite_data(pwdata[1]),
        .PRead_ready(pr_rdy[1]), .PRead_data(prdata[1]),
        .PWrite_ready(pw_rdy[1]),
        .MRead_request(mr_req[1]), .MRead_ready(mr_rdy[1]),
        .MRead_data(mr_data[1]),
        .MWrite_request(mw_req[1]), .MWrite_ready(mw_rdy[1]),
        .MWrite_data(mw_data[1]), .MWrite_mask(mw_mask[1]),
        .MAddress(maddr[1]),
        .hit_count(hit_b), .miss_count(miss_b), .busy(busy[1])
    );

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic push(input int d, input ev_e k, input logic [AW-1:0] a,
                        input logic [LW-1:0] dt, input logic [WPL-1:0] m);
        exp_t e;
        e.dut  = d;
        e.kind = k;
        e.addr = a;
        e.data = dt;
        e.mask = m;
        q.push_back(e);
    endtask

    task automatic sb_pop(input int d, input ev_e k, input logic [AW-1:0] a,
                          input logic [LW-1:0] dt, input logic [WPL-1:0] m);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL sb unexpected dut%0d kind %0d addr %h data %h mask %h",
                     d, k, a, dt, m);
            return;
        end
        e = q.pop_front();
        if (e.dut != d || e.kind != k || e.addr !== a ||
            e.data !== dt || e.mask !== m) begin
            errors++;
            $display("FAIL sb got dut%0d kind %0d addr %h data %h mask %h want dut%0d kind %0d addr %h data %h mask %h",
                     d, k, a, dt, m, e.dut, e.kind, e.addr, e.data, e.mask);
        end
    endtask

    // Monitor: every response pulse and every memory request start.
    logic mr_prev [2];
    logic mw_prev [2];

    initial begin
        mr_prev = '{1'b0, 1'b0};
        mw_prev = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (pr_rdy[d]) sb_pop(d, EV_RD, '0, LW'(prdata[d]), '0);
                if (pw_rdy[d]) sb_pop(d, EV_WR, '0, '0, '0);
                if (mr_req[d] && !mr_prev[d])
                    sb_pop(d, EV_MR, maddr[d], '0, '0);
                if (mw_req[d] && !mw_prev[d])
                    sb_pop(d, EV_MW, maddr[d], mw_data[d], mw_mask[d]);
                mr_prev[d] = mr_req[d];
                mw_prev[d] = mw_req[d];
            end
        end
    end

    // Memory model: ready on the third cycle a request is held.
    int mr_cnt [2];
    int mw_cnt [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            mr_rdy[d]  = 1'b0;
            mw_rdy[d]  = 1'b0;
            mr_data[d] = '0;
            mr_cnt[d]  = 0;
            mw_cnt[d]  = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                mr_cnt[d]  = mr_req[d] ? mr_cnt[d] + 1 : 0;
                mw_cnt[d]  = mw_req[d] ? mw_cnt[d] + 1 : 0;
                mr_rdy[d]  = mr_req[d] && (mr_cnt[d] == 3);
                mw_rdy[d]  = mw_req[d] && (mw_cnt[d] == 3);
                mr_data[d] = mr_rdy[d] ? 32'hDDCC_BBAA : '0;
            end
        end
    end

    function automatic logic sel(input int d, input int which);
        case (which)
            0:       return pr_rdy[d];
            1:       return pw_rdy[d];
            default: return mr_req[d];
        endcase
    endfunction

    task automatic wait_for(input int d, input int which, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sel(d, which) && n < 60);
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL timeout %s got no event want event within 60 cycles", name);
        end
    endtask

    task automatic do_req(input int d, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd);
        @(negedge clk);
        paddr[d]  = a;
        pwdata[d] = wd;
        if (wr) pw_req[d] = 1'b1;
        else    pr_req[d] = 1'b1;
        wait_for(d, wr ? 1 : 0, wr ? "write" : "read");
        pr_req[d] = 1'b0;
        pw_req[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            pr_req[d] = 1'b0;
            pw_req[d] = 1'b0;
            paddr[d]  = '0;
            pwdata[d] = '0;
        end
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_maddr", 32'(maddr[0]), 32'h0);
        chk("rst_counts", {hit_a, miss_a, hit_b[7:0], miss_b[7:0]}, 32'h0);
        rst = 1'b0;

        // Write-back: read miss 0x03 fills line 0.
        push(0, EV_MR, 8'h00, '0, '0);
        push(0, EV_RD, '0, 32'hDD, '0);
        do_req(0, 1'b0, 8'h03, 8'h00);
        chk("miss_cnt_1", 32'(miss_a), 32'd1);
        chk("hit_cnt_0", 32'(hit_a), 32'd0);

        // Read hit 0x02, response exactly two edges after sampling.
        push(0, EV_RD, '0, 32'hCC, '0);
        @(negedge clk);
        paddr[0]  = 8'h02;
        pr_req[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("hit_lat_rdy", 32'(pr_rdy[0]), 32'h1);
        chk("hit_lat_data", 32'(prdata[0]), 32'hCC);
        @(negedge clk);
        pr_req[0] = 1'b0;
        @(negedge clk);
        chk("hit_cnt_1", 32'(hit_a), 32'd1);

        // Write hit 0x01 = 0x55, no memory traffic expected.
        push(0, EV_WR, '0, '0, '0);
        do_req(0, 1'b1, 8'h01, 8'h55);
        chk("hit_cnt_2", 32'(hit_a), 32'd2);

        // Read 0x43: dirty line 0 evicted then refilled with tag 1.
        push(0, EV_MW, 8'h00, 32'hDDCC_55AA, 4'hF);
        push(0, EV_MR, 8'h40, '0, '0);
        push(0, EV_RD, '0, 32'hDD, '0);
        do_req(0, 1'b0, 8'h43, 8'h00);
        chk("miss_cnt_2", 32'(miss_a), 32'd2);

        // Simultaneous write and read of 0x42: write first.
        push(0, EV_WR, '0, '0, '0);
        push(0, EV_RD, '0, 32'h99, '0);
        @(negedge clk);
        paddr[0]  = 8'h42;
        pwdata[0] = 8'h99;
        pw_req[0] = 1'b1;
        pr_req[0] = 1'b1;
        wait_for(0, 1, "simul_write");
        pw_req[0] = 1'b0;
        wait_for(0, 0, "simul_read");
        pr_req[0] = 1'b0;
        @(negedge clk);
        chk("hit_cnt_sat", 32'(hit_a), 32'd3);

        // Reset while refilling 0x85 drops the memory request at once.
        push(0, EV_MR, 8'h84, '0, '0);
        @(negedge clk);
        paddr[0]  = 8'h85;
        pr_req[0] = 1'b1;
        wait_for(0, 2, "refill_start");
        #2 rst = 1'b1;
        #1;
        chk("rst_mreq", 32'(mr_req[0]), 32'h0);
        chk("rst_busy_mid", 32'(busy[0]), 32'h0);
        chk("rst_maddr_mid", 32'(maddr[0]), 32'h0);
        chk("rst_cnt_mid", 32'({hit_a, miss_a}), 32'h0);
        pr_req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Valid bits cleared: 0x02 misses again.
        push(0, EV_MR, 8'h00, '0, '0);
        push(0, EV_RD, '0, 32'hCC, '0);
        do_req(0, 1'b0, 8'h02, 8'h00);
        chk("miss_after_rst", 32'(miss_a), 32'd1);
        chk("hit_after_rst", 32'(hit_a), 32'd0);

        // Write-through: write miss 0x06 goes straight to memory.
        push(1, EV_MW, 8'h04, 32'h7777_7777, 4'h4);
        push(1, EV_WR, '0, '0, '0);
        do_req(1, 1'b1, 8'h06, 8'h77);
        chk("wt_miss_1", 32'(miss_b), 32'd1);

        // Line 1 was not allocated: read 0x06 misses.
        push(1, EV_MR, 8'h04, '0, '0);
        push(1, EV_RD, '0, 32'hCC, '0);
        do_req(1, 1'b0, 8'h06, 8'h00);
        chk("wt_miss_2", 32'(miss_b), 32'd2);
        chk("wt_hit_0", 32'(hit_b), 32'd0);

        // Write hit 0x05 updates the line and writes through.
        push(1, EV_MW, 8'h04, 32'h1111_1111, 4'h2);
        push(1, EV_WR, '0, '0, '0);
        do_req(1, 1'b1, 8'h05, 8'h11);
        chk("wt_hit_1", 32'(hit_b), 32'd1);

        push(1, EV_RD, '0, 32'h11, '0);
        do_req(1, 1'b0, 8'h05, 8'h00);
        chk("wt_hit_2", 32'(hit_b), 32'd2);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
